// File: rtl/mem_req_arbiter_if.sv
// rtl/mem_req_arbiter_if.sv - client request, memory request and tagged response bundle for mem_req_arbiter
interface mem_req_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int TAG_W     = 4
);
  logic [NUM_PORTS-1:0]        req_valid;
  logic [NUM_PORTS-1:0]        req_ready;
  logic [NUM_PORTS-1:0]        req_we;
  logic [NUM_PORTS*ADDR_W-1:0] req_addr;
  logic [NUM_PORTS*DATA_W-1:0] req_wdata;
  logic                        mem_req_valid;
  logic                        mem_req_ready;
  logic                        mem_req_we;
  logic [ADDR_W-1:0]           mem_req_addr;
  logic [DATA_W-1:0]           mem_req_wdata;
  logic [TAG_W-1:0]            mem_req_tag;
  logic                        mem_rsp_valid;
  logic [TAG_W-1:0]            mem_rsp_tag;
  logic [DATA_W-1:0]           mem_rsp_data;
  logic [NUM_PORTS-1:0]        rsp_valid;
  logic [DATA_W-1:0]           rsp_data;
  logic                        err_spurious;

  // Arbiter side
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_tag, mem_rsp_data,
    output req_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_tag,
    output rsp_valid, rsp_data, err_spurious
  );

  // Client and memory side
  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_tag, mem_rsp_data,
    input  req_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_tag,
    input  rsp_valid, rsp_data, err_spurious
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - round-robin request merger with tag allocation and response routing
module mem_req_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  mem_req_arbiter_if.slave bus
);
  localparam int NTAGS = 1 << TAG_W;
  localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int PW1   = PW + 1;

  logic                 mem_req_valid_q, mem_req_valid_d;
  logic                 mem_req_we_q, mem_req_we_d;
  logic [ADDR_W-1:0]    mem_req_addr_q, mem_req_addr_d;
  logic [DATA_W-1:0]    mem_req_wdata_q, mem_req_wdata_d;
  logic [TAG_W-1:0]     mem_req_tag_q, mem_req_tag_d;
  logic [NTAGS-1:0]     free_q, free_d;
  logic [PW-1:0]        owner_q [NTAGS];
  logic [PW-1:0]        owner_d [NTAGS];
  logic [PW-1:0]        rr_q, rr_d;
  logic [NUM_PORTS-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
  logic                 err_q, err_d;

  logic                 can_load, found, grant, rsp_hit, tag_avail;
  logic [PW-1:0]        winner;
  logic [PW1-1:0]       cand;
  logic [TAG_W-1:0]     alloc_tag;
  logic [NUM_PORTS-1:0] req_ready;

  // Descending scan so the last hit is the closest port at or after rr_q
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      cand = PW1'(rr_q) + PW1'(k);
      if (cand >= PW1'(NUM_PORTS)) begin
        cand = cand - PW1'(NUM_PORTS);
      end
      if (bus.req_valid[cand[PW-1:0]]) begin
        found  = 1'b1;
        winner = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    tag_avail = |free_q;
    alloc_tag = '0;
    for (int t = NTAGS - 1; t >= 0; t--) begin
      if (free_q[t]) begin
        alloc_tag = TAG_W'(t);
      end
    end
  end

  always_comb begin
    can_load  = !mem_req_valid_q || bus.mem_req_ready;
    grant     = reset && can_load && tag_avail && found;
    req_ready = grant ? (NUM_PORTS'(1) << winner) : '0;
    rsp_hit   = bus.mem_rsp_valid && !free_q[bus.mem_rsp_tag];
  end

  // Allocation reads free_q, so a tag retiring this edge is never handed out on it
  always_comb begin
    mem_req_valid_d = mem_req_valid_q;
    mem_req_we_d    = mem_req_we_q;
    mem_req_addr_d  = mem_req_addr_q;
    mem_req_wdata_d = mem_req_wdata_q;
    mem_req_tag_d   = mem_req_tag_q;
    free_d          = free_q;
    owner_d         = owner_q;
    rr_d            = rr_q;
    rsp_valid_d     = '0;
    rsp_data_d      = rsp_data_q;
    err_d           = err_q | (bus.mem_rsp_valid && free_q[bus.mem_rsp_tag]);

    if (grant) begin
      mem_req_valid_d    = 1'b1;
      mem_req_we_d       = bus.req_we[winner];
      mem_req_addr_d     = bus.req_addr[winner*ADDR_W +: ADDR_W];
      mem_req_wdata_d    = bus.req_wdata[winner*DATA_W +: DATA_W];
      mem_req_tag_d      = alloc_tag;
      free_d[alloc_tag]  = 1'b0;
      owner_d[alloc_tag] = winner;
      rr_d               = (winner == PW'(NUM_PORTS - 1)) ? '0 : winner + PW'(1);
    end else if (bus.mem_req_ready) begin
      mem_req_valid_d = 1'b0;
    end

    if (rsp_hit) begin
      free_d[bus.mem_rsp_tag] = 1'b1;
      rsp_valid_d             = NUM_PORTS'(1) << owner_q[bus.mem_rsp_tag];
      rsp_data_d              = bus.mem_rsp_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req_valid_q <= 1'b0;
      mem_req_we_q    <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_wdata_q <= '0;
      mem_req_tag_q   <= '0;
      free_q          <= '1;
      for (int t = 0; t < NTAGS; t++) begin
        owner_q[t] <= '0;
      end
      rr_q            <= '0;
      rsp_valid_q     <= '0;
      rsp_data_q      <= '0;
      err_q           <= 1'b0;
    end else begin
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_we_q    <= mem_req_we_d;
      mem_req_addr_q  <= mem_req_addr_d;
      mem_req_wdata_q <= mem_req_wdata_d;
      mem_req_tag_q   <= mem_req_tag_d;
      free_q          <= free_d;
      owner_q         <= owner_d;
      rr_q            <= rr_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      err_q           <= err_d;
    end
  end

  assign bus.req_ready     = req_ready;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_we    = mem_req_we_q;
  assign bus.mem_req_addr  = mem_req_addr_q;
  assign bus.mem_req_wdata = mem_req_wdata_q;
  assign bus.mem_req_tag   = mem_req_tag_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.err_spurious  = err_q;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - self-checking bench for mem_req_arbiter
module tb_mem_req_arbiter;
  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int TW = 4;
  localparam int NT = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_req_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .TAG_W(TW)) bus ();
  mem_req_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .TAG_W(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: owner per tag (-1 = free), pointer, output stage, response
  int           m_owner [NT];
  int           m_rr;
  bit           m_ov, m_owe;
  logic [AW-1:0] m_oaddr;
  logic [DW-1:0] m_owdata;
  int           m_otag;
  logic [NP-1:0] m_rspv;
  logic [DW-1:0] m_rspd;
  bit           m_err;
  int           issued [$];

  typedef struct {
    logic [NP-1:0] rv;
    logic          rdy;
    logic [NP-1:0] exp_ready;
    logic          exp_valid;
    logic [TW-1:0] exp_tag;
  } vec_t;
  vec_t vt [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic m_reset();
    for (int t = 0; t < NT; t++) m_owner[t] = -1;
    m_rr = 0; m_ov = 0; m_owe = 0; m_oaddr = '0; m_owdata = '0; m_otag = 0;
    m_rspv = '0; m_rspd = '0; m_err = 0;
    issued.delete();
  endtask

  function automatic int m_winner();
    int nfree = 0;
    for (int t = 0; t < NT; t++) if (m_owner[t] < 0) nfree++;
    if ((m_ov && !bus.mem_req_ready) || nfree == 0) return -1;
    for (int k = 0; k < NP; k++) if (bus.req_valid[(m_rr + k) % NP]) return (m_rr + k) % NP;
    return -1;
  endfunction

  function automatic int m_lowest_free();
    for (int t = 0; t < NT; t++) if (m_owner[t] < 0) return t;
    return -1;
  endfunction

  task automatic drive_idle();
    bus.req_valid = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_req_ready = 1'b1; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_tag = '0; bus.mem_rsp_data = '0;
  endtask

  // Compare DUT to model with current inputs, then advance both one clock
  task automatic cycle();
    int w, a, rt;
    logic [NP-1:0] exp_rdy, nrspv;
    #1;
    w = m_winner();
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("mem_req_valid", bus.mem_req_valid, m_ov);
    if (m_ov) begin
      chk("mem_req_tag", bus.mem_req_tag, m_otag);
      chk("mem_req_addr", bus.mem_req_addr, m_oaddr);
      chk("mem_req_we", bus.mem_req_we, m_owe);
      chk("mem_req_wdata", bus.mem_req_wdata, m_owdata);
    end
    chk("rsp_valid", bus.rsp_valid, m_rspv);
    chk("rsp_data", bus.rsp_data, m_rspd);
    chk("err_spurious", bus.err_spurious, m_err);

    if (m_ov && bus.mem_req_ready) issued.push_back(m_otag);
    nrspv = '0;
    rt = -1;
    if (bus.mem_rsp_valid) begin
      if (m_owner[bus.mem_rsp_tag] >= 0) begin
        nrspv[m_owner[bus.mem_rsp_tag]] = 1'b1;
        m_rspd = bus.mem_rsp_data;
        rt = int'(bus.mem_rsp_tag);
      end else begin
        m_err = 1;
      end
    end
    if (w >= 0) begin
      a = m_lowest_free();
      m_owner[a] = w;
      m_ov = 1;
      m_owe = bus.req_we[w];
      m_oaddr = bus.req_addr[w*AW +: AW];
      m_owdata = bus.req_wdata[w*DW +: DW];
      m_otag = a;
      m_rr = (w + 1) % NP;
    end else if (bus.mem_req_ready) begin
      m_ov = 0;
    end
    if (rt >= 0) m_owner[rt] = -1;
    m_rspv = nrspv;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst req_ready", bus.req_ready, 0);
    chk("rst mem_req_valid", bus.mem_req_valid, 0);
    chk("rst mem_req_we", bus.mem_req_we, 0);
    chk("rst mem_req_addr", bus.mem_req_addr, 0);
    chk("rst mem_req_wdata", bus.mem_req_wdata, 0);
    chk("rst mem_req_tag", bus.mem_req_tag, 0);
    chk("rst rsp_valid", bus.rsp_valid, 0);
    chk("rst rsp_data", bus.rsp_data, 0);
    chk("rst err_spurious", bus.err_spurious, 0);
    m_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic fill(input int c);
    drive_idle();
    bus.req_valid[c] = 1'b1;
    for (int i = 0; i < NT; i++) begin
      bus.req_addr[c*AW +: AW] = 32'h2000 + 32'(i);
      cycle();
      chk("fill valid", bus.mem_req_valid, 1);
      chk("fill tag order", bus.mem_req_tag, i);
    end
    cycle();
    chk("exhausted mem_req_valid", bus.mem_req_valid, 0);
    chk("exhausted req_ready", bus.req_ready, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{4'b1111, 1'b1, 4'b0001, 1'b0, 4'd0};
    vt[1] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 4'd0};
    vt[2] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 4'd1};
    vt[3] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 4'd2};
    vt[4] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 4'd2};
    vt[5] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 4'd2};
    vt[6] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 4'd3};
    vt[7] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 4'd4};
    vt[8] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 4'd5};
    vt[9] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'd0};

    drive_idle();
    #1;
    do_reset();
    cycle();

    // Round robin with a backpressure window; client 2 carries address 0x1000
    for (int i = 0; i < 10; i++) begin
      bus.req_valid = vt[i].rv;
      bus.mem_req_ready = vt[i].rdy;
      for (int p = 0; p < NP; p++) bus.req_addr[p*AW +: AW] = 32'h0E00 + 32'(p) * 32'h100;
      #1;
      chk("tbl req_ready", bus.req_ready, vt[i].exp_ready);
      chk("tbl mem_req_valid", bus.mem_req_valid, vt[i].exp_valid);
      if (vt[i].exp_valid) chk("tbl mem_req_tag", bus.mem_req_tag, vt[i].exp_tag);
      if (vt[i].exp_valid && vt[i].exp_tag == 4'd2) chk("tbl held addr", bus.mem_req_addr, 32'h1000);
      cycle();
    end

    // Asynchronous reset with tags in flight and requests pending
    bus.req_valid = '1;
    do_reset();
    fill(0);
    do_reset();
    fill(1);

    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_tag = 4'd5; bus.mem_rsp_data = 64'h55AA;
    cycle();
    bus.mem_rsp_valid = 1'b0;
    chk("tag5 rsp_valid", bus.rsp_valid, 4'b0010);
    chk("tag5 rsp_data", bus.rsp_data, 64'h55AA);
    chk("tag5 req_ready", bus.req_ready, 4'b0010);
    cycle();
    chk("reuse tag5", bus.mem_req_tag, 5);
    chk("rsp pulse width", bus.rsp_valid, 0);

    // Out-of-order routing and spurious response
    do_reset();
    drive_idle();
    bus.req_valid = 4'b1100; cycle();
    bus.req_valid = 4'b1000; cycle();
    bus.req_valid = 4'b0000; cycle();
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_tag = 4'd7; bus.mem_rsp_data = 64'hDEAD;
    cycle();
    bus.mem_rsp_valid = 1'b0;
    chk("spurious err", bus.err_spurious, 1);
    chk("spurious no pulse", bus.rsp_valid, 0);
    bus.req_valid = 4'b0001; cycle();
    bus.req_valid = 4'b0000;
    chk("free map unchanged", bus.mem_req_tag, 2);
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_tag = 4'd1; bus.mem_rsp_data = 64'hAA;
    cycle();
    chk("ooo rsp_valid tag1", bus.rsp_valid, 4'b1000);
    chk("ooo rsp_data tag1", bus.rsp_data, 64'hAA);
    bus.mem_rsp_tag = 4'd0; bus.mem_rsp_data = 64'hBB;
    cycle();
    bus.mem_rsp_valid = 1'b0;
    chk("ooo rsp_valid tag0", bus.rsp_valid, 4'b0100);
    chk("ooo rsp_data tag0", bus.rsp_data, 64'hBB);
    cycle();
    chk("err sticky", bus.err_spurious, 1);

    // Randomized traffic against the model; phase 0 starves responses to hit exhaustion
    do_reset();
    drive_idle();
    for (int i = 0; i < 3000; i++) begin
      bus.req_valid = NP'($urandom);
      bus.req_we = NP'($urandom);
      for (int p = 0; p < NP; p++) begin
        bus.req_addr[p*AW +: AW] = $urandom;
        bus.req_wdata[p*DW +: DW] = {$urandom, $urandom};
      end
      bus.mem_req_ready = ($urandom_range(0, 3) != 0);
      bus.mem_rsp_data = {$urandom, $urandom};
      if (issued.size() > 0 && $urandom_range(0, (i < 1000) ? 7 : 2) == 0) begin
        int idx;
        idx = $urandom_range(0, issued.size() - 1);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_tag = TW'(issued[idx]);
        issued.delete(idx);
      end else begin
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_tag = TW'($urandom);
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
